// File: rtl/oam_dma_engine_if.sv
// Router-facing DMA bus of the OAM DMA engine: one read master port and one write master port.
// The engine uses the master view and the memory router uses the slave view.
interface oam_dma_engine_if;
  logic [15:0] O_RDMA_ADDR;
  logic        O_RDMA_RE_L;
  logic [7:0]  I_RDMA_DATA;
  logic [15:0] O_WDMA_ADDR;
  logic [7:0]  O_WDMA_DATA;
  logic        O_WDMA_WE_L;

  modport master (
    output O_RDMA_ADDR, O_RDMA_RE_L, O_WDMA_ADDR, O_WDMA_DATA, O_WDMA_WE_L,
    input  I_RDMA_DATA
  );

  modport slave (
    input  O_RDMA_ADDR, O_RDMA_RE_L, O_WDMA_ADDR, O_WDMA_DATA, O_WDMA_WE_L,
    output I_RDMA_DATA
  );
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA controller: a write to the DMA register copies LENGTH bytes from page V into OAM.
// Every DMA output is a flop loaded from the next-state decode, so outputs follow the current state.
//
// state | meaning
// IDLE  | no transfer; both strobes high
// START | one cycle; clears byte index and read counter
// READ  | source read strobe low for READ_LATENCY cycles; data captured on the last edge
// WRITE | one cycle; destination write strobe low, then next byte or IDLE
module oam_dma_engine #(
  parameter logic [15:0] REG_ADDR     = 16'hFF46,
  parameter logic [15:0] DEST_BASE    = 16'hFE00,
  parameter int          LENGTH       = 160,
  parameter int          READ_LATENCY = 1
) (
  input  logic             I_CLK,
  input  logic             I_SYNC_RESET_L,
  input  logic [15:0]      I_ADDR_BUS,
  inout  wire  [7:0]       IO_DATA_BUS,
  input  logic             I_WE_BUS_L,
  input  logic             I_RE_BUS_L,
  oam_dma_engine_if.master dma,
  output logic             O_DMA_ACTIVE,
  output logic [7:0]       O_DATA_READ
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_READ, ST_WRITE} state_t;

  localparam logic [9:0] LEN_W   = 10'(LENGTH);
  localparam logic [1:0] RD_LAST = 2'(READ_LATENCY - 1);

  state_t      state, state_nx;
  logic [8:0]  idx, idx_nx, idx_inc;
  logic [1:0]  rd_cnt, rd_cnt_nx;
  logic [7:0]  dma_reg;
  logic [7:0]  src_page;
  logic [15:0] src_addr;
  logic        reg_wr, reg_rd;

  logic [15:0] rd_addr, wr_addr;
  logic [7:0]  wr_data;
  logic        rd_re_l, wr_we_l, active;

  assign reg_wr = !I_WE_BUS_L && (I_ADDR_BUS == REG_ADDR);
  assign reg_rd = !I_RE_BUS_L && (I_ADDR_BUS == REG_ADDR);

  assign IO_DATA_BUS = reg_rd ? dma_reg : 8'bz;
  assign O_DATA_READ = dma_reg;

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    rd_cnt_nx = rd_cnt;
    idx_inc   = idx + 9'd1;
    case (state)
      ST_IDLE: ;
      ST_START: begin
        idx_nx    = 9'd0;
        rd_cnt_nx = 2'd0;
        state_nx  = ST_READ;
      end
      ST_READ: begin
        if (rd_cnt == RD_LAST) begin
          rd_cnt_nx = 2'd0;
          state_nx  = ST_WRITE;
        end else begin
          rd_cnt_nx = rd_cnt + 2'd1;
        end
      end
      ST_WRITE: begin
        idx_nx   = idx_inc;
        state_nx = ({1'b0, idx_inc} < LEN_W) ? ST_READ : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // A register write always wins: the pulse in flight finishes, a partial read is dropped.
    if (reg_wr) begin
      state_nx  = ST_START;
      idx_nx    = 9'd0;
      rd_cnt_nx = 2'd0;
    end
  end

  // Pages E0..FF alias the work-RAM echo, so fold them down by 0x20.
  always_comb begin
    src_page = (dma_reg >= 8'hE0) ? (dma_reg - 8'h20) : dma_reg;
    src_addr = {src_page, 8'h00} + {7'd0, idx_nx};
  end

  always_ff @(posedge I_CLK) begin
    if (!I_SYNC_RESET_L) begin
      state   <= ST_IDLE;
      idx     <= 9'd0;
      rd_cnt  <= 2'd0;
      dma_reg <= 8'h00;
      rd_re_l <= 1'b1;
      wr_we_l <= 1'b1;
      active  <= 1'b0;
      rd_addr <= 16'h0000;
      wr_addr <= 16'h0000;
      wr_data <= 8'h00;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      rd_cnt  <= rd_cnt_nx;
      if (reg_wr) dma_reg <= IO_DATA_BUS;
      rd_re_l <= (state_nx != ST_READ);
      wr_we_l <= (state_nx != ST_WRITE);
      active  <= (state_nx != ST_IDLE);
      if (state_nx == ST_READ) rd_addr <= src_addr;
      if (state_nx == ST_WRITE) begin
        wr_addr <= DEST_BASE + {7'd0, idx_nx};
        wr_data <= dma.I_RDMA_DATA;
      end
    end
  end

  assign dma.O_RDMA_ADDR = rd_addr;
  assign dma.O_RDMA_RE_L = rd_re_l;
  assign dma.O_WDMA_ADDR = wr_addr;
  assign dma.O_WDMA_DATA = wr_data;
  assign dma.O_WDMA_WE_L = wr_we_l;
  assign O_DMA_ACTIVE    = active;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: a default instance and a READ_LATENCY=3, LENGTH=4 instance,
// each with a small router model and a negedge monitor logging write pulses and active cycles.
module tb_oam_dma_engine;
  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  // default instance
  logic [15:0] addr1;
  logic        we1, re1, io1_drv;
  logic [7:0]  io1_val;
  wire  [7:0]  io1;
  logic        active1;
  logic [7:0]  dread1;
  assign io1 = io1_drv ? io1_val : 8'bz;
  oam_dma_engine_if dma1();
  assign dma1.I_RDMA_DATA = dma1.O_RDMA_RE_L ? 8'h00 : dma1.O_RDMA_ADDR[7:0];

  oam_dma_engine u_dut (
    .I_CLK(clk), .I_SYNC_RESET_L(rst_l), .I_ADDR_BUS(addr1), .IO_DATA_BUS(io1),
    .I_WE_BUS_L(we1), .I_RE_BUS_L(re1), .dma(dma1), .O_DMA_ACTIVE(active1), .O_DATA_READ(dread1)
  );

  // latency instance: router data is only valid on the third low cycle of the read strobe
  logic [15:0] addr2;
  logic        we2, re2, io2_drv;
  logic [7:0]  io2_val;
  wire  [7:0]  io2;
  logic        active2;
  logic [7:0]  dread2;
  int          low_cnt2 = 0;
  assign io2 = io2_drv ? io2_val : 8'bz;
  oam_dma_engine_if dma2();
  assign dma2.I_RDMA_DATA = (!dma2.O_RDMA_RE_L && low_cnt2 == 2) ? dma2.O_RDMA_ADDR[7:0] : 8'hEE;
  always @(posedge clk) low_cnt2 <= dma2.O_RDMA_RE_L ? 0 : low_cnt2 + 1;

  oam_dma_engine #(.READ_LATENCY(3), .LENGTH(4)) u_lat (
    .I_CLK(clk), .I_SYNC_RESET_L(rst_l), .I_ADDR_BUS(addr2), .IO_DATA_BUS(io2),
    .I_WE_BUS_L(we2), .I_RE_BUS_L(re2), .dma(dma2), .O_DMA_ACTIVE(active2), .O_DATA_READ(dread2)
  );

  logic [15:0] wa1_q[$], src1_q[$], wa2_q[$], src2_q[$];
  logic [7:0]  wd1_q[$], wd2_q[$];
  logic [15:0] last_src1 = 16'h0, last_src2 = 16'h0;
  int act1 = 0, act2 = 0, ovl1 = 0, ovl2 = 0, relow2 = 0;

  always @(negedge clk) begin
    if (!dma1.O_RDMA_RE_L) last_src1 <= dma1.O_RDMA_ADDR;
    if (!dma1.O_WDMA_WE_L) begin
      wa1_q.push_back(dma1.O_WDMA_ADDR); wd1_q.push_back(dma1.O_WDMA_DATA); src1_q.push_back(last_src1);
    end
    if (active1) act1 <= act1 + 1;
    if (!dma1.O_RDMA_RE_L && !dma1.O_WDMA_WE_L) ovl1 <= ovl1 + 1;
    if (!dma2.O_RDMA_RE_L) begin last_src2 <= dma2.O_RDMA_ADDR; relow2 <= relow2 + 1; end
    if (!dma2.O_WDMA_WE_L) begin
      wa2_q.push_back(dma2.O_WDMA_ADDR); wd2_q.push_back(dma2.O_WDMA_DATA); src2_q.push_back(last_src2);
    end
    if (active2) act2 <= act2 + 1;
    if (!dma2.O_RDMA_RE_L && !dma2.O_WDMA_WE_L) ovl2 <= ovl2 + 1;
  end

  task automatic io_wr1(input logic [7:0] v);
    @(negedge clk); addr1 = 16'hFF46; io1_val = v; io1_drv = 1'b1; we1 = 1'b0;
    @(posedge clk); #1; we1 = 1'b1; io1_drv = 1'b0; addr1 = 16'h0000;
  endtask

  task automatic io_wr2(input logic [7:0] v);
    @(negedge clk); addr2 = 16'hFF46; io2_val = v; io2_drv = 1'b1; we2 = 1'b0;
    @(posedge clk); #1; we2 = 1'b1; io2_drv = 1'b0; addr2 = 16'h0000;
  endtask

  task automatic wait_idle(input int which, input int budget, output bit timed_out);
    int n = 0;
    while (((which == 1) ? active1 : active2) && n < budget) begin @(negedge clk); n++; end
    timed_out = (which == 1) ? active1 : active2;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if ({dma1.O_RDMA_RE_L, dma1.O_WDMA_WE_L, active1} !== 3'b110) begin
      fails++; $display("FAIL reset_strobes: got re/we/act=%b required 110", {dma1.O_RDMA_RE_L, dma1.O_WDMA_WE_L, active1}); end
    tests++; if ({dma1.O_RDMA_ADDR, dma1.O_WDMA_ADDR, dma1.O_WDMA_DATA} !== 40'h0) begin
      fails++; $display("FAIL reset_addr_data: got %h/%h/%h required 0", dma1.O_RDMA_ADDR, dma1.O_WDMA_ADDR, dma1.O_WDMA_DATA); end
    tests++; if (dread1 !== 8'h00) begin fails++; $display("FAIL reset_dma_reg: got %h required 00", dread1); end
    io1_val = 8'h5A; io1_drv = 1'b1; #1;
    tests++; if (io1 !== 8'h5A) begin fails++; $display("FAIL reset_bus_float: got %h required 5a (dut off the bus)", io1); end
    io1_drv = 1'b0;
    tests++; if ({dma2.O_RDMA_RE_L, dma2.O_WDMA_WE_L, active2} !== 3'b110) begin
      fails++; $display("FAIL reset_lat_strobes: got %b required 110", {dma2.O_RDMA_RE_L, dma2.O_WDMA_WE_L, active2}); end
    @(negedge clk); rst_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int wb, ab, ob;
    bit to;
    wb = wa1_q.size(); ab = act1; ob = ovl1;
    io_wr1(8'hC1);
    @(negedge clk);
    tests++; if ({dma1.O_RDMA_RE_L, active1} !== 2'b11) begin
      fails++; $display("FAIL basic_start: got re/act=%b required 11", {dma1.O_RDMA_RE_L, active1}); end
    @(negedge clk);
    tests++; if (dma1.O_RDMA_RE_L !== 1'b0 || dma1.O_RDMA_ADDR !== 16'hC100) begin
      fails++; $display("FAIL basic_first_read: got re=%b addr=%h required 0/c100", dma1.O_RDMA_RE_L, dma1.O_RDMA_ADDR); end
    wait_idle(1, 1000, to);
    tests++; if (to) begin fails++; $display("FAIL basic_timeout: active still 1 required 0"); end
    tests++; if (act1 - ab !== 321) begin fails++; $display("FAIL basic_active_cycles: got %0d required 321", act1 - ab); end
    tests++; if (wa1_q.size() - wb !== 160) begin fails++; $display("FAIL basic_write_count: got %0d required 160", wa1_q.size() - wb); end
    for (int i = 0; i < 160 && wb + i < wa1_q.size(); i++) begin
      tests++;
      if (wa1_q[wb+i] !== 16'hFE00 + 16'(i) || wd1_q[wb+i] !== 8'(i) || src1_q[wb+i] !== 16'hC100 + 16'(i)) begin
        fails++; $display("FAIL basic_byte%0d: got dst=%h data=%h src=%h required %h/%h/%h", i,
          wa1_q[wb+i], wd1_q[wb+i], src1_q[wb+i], 16'hFE00 + 16'(i), 8'(i), 16'hC100 + 16'(i)); end
    end
    tests++; if (ovl1 - ob !== 0) begin fails++; $display("FAIL basic_strobe_overlap: got %0d required 0", ovl1 - ob); end
  endtask

  task automatic test_readback_echo();
    int wb, ab;
    bit to;
    wb = wa1_q.size(); ab = act1;
    io_wr1(8'hE3);
    @(negedge clk); re1 = 1'b0; addr1 = 16'hFF46; #1;
    tests++; if (io1 !== 8'hE3) begin fails++; $display("FAIL readback_bus: got %h required e3", io1); end
    tests++; if (dread1 !== 8'hE3) begin fails++; $display("FAIL readback_data_read: got %h required e3", dread1); end
    @(negedge clk);
    tests++; if (dma1.O_RDMA_RE_L !== 1'b0 || dma1.O_RDMA_ADDR !== 16'hC300) begin
      fails++; $display("FAIL echo_first_src: got re=%b addr=%h required 0/c300", dma1.O_RDMA_RE_L, dma1.O_RDMA_ADDR); end
    addr1 = 16'hFF45; io1_val = 8'h5A; io1_drv = 1'b1; #1;
    tests++; if (io1 !== 8'h5A) begin fails++; $display("FAIL readback_other_addr: got %h required 5a (dut off the bus)", io1); end
    re1 = 1'b1; io1_drv = 1'b0; addr1 = 16'h0000;
    wait_idle(1, 1000, to);
    tests++; if (to) begin fails++; $display("FAIL echo_timeout: active still 1 required 0"); end
    tests++; if (act1 - ab !== 321) begin fails++; $display("FAIL echo_active_cycles: got %0d required 321", act1 - ab); end
    tests++; if (wa1_q.size() - wb !== 160) begin fails++; $display("FAIL echo_write_count: got %0d required 160", wa1_q.size() - wb); end
    else begin
      tests++; if (src1_q[wb+159] !== 16'hC39F || wa1_q[wb+159] !== 16'hFE9F) begin
        fails++; $display("FAIL echo_last_byte: got src=%h dst=%h required c39f/fe9f", src1_q[wb+159], wa1_q[wb+159]); end
    end
  endtask

  task automatic test_restart();
    int wb, rb;
    bit to;
    wb = wa1_q.size();
    io_wr1(8'h80);
    repeat (49) @(negedge clk);
    io_wr1(8'h90);
    rb = wa1_q.size();
    tests++; if (rb - wb !== 24) begin fails++; $display("FAIL restart_pre_writes: got %0d required 24", rb - wb); end
    @(negedge clk);
    tests++; if ({dma1.O_RDMA_RE_L, dma1.O_WDMA_WE_L, active1} !== 3'b111) begin
      fails++; $display("FAIL restart_start: got re/we/act=%b required 111", {dma1.O_RDMA_RE_L, dma1.O_WDMA_WE_L, active1}); end
    wait_idle(1, 1000, to);
    tests++; if (to) begin fails++; $display("FAIL restart_timeout: active still 1 required 0"); end
    tests++; if (wa1_q.size() - rb !== 160) begin fails++; $display("FAIL restart_write_count: got %0d required 160", wa1_q.size() - rb); end
    for (int i = 0; i < 160 && rb + i < wa1_q.size(); i++) begin
      tests++;
      if (wa1_q[rb+i] !== 16'hFE00 + 16'(i) || src1_q[rb+i] !== 16'h9000 + 16'(i)) begin
        fails++; $display("FAIL restart_byte%0d: got dst=%h src=%h required %h/%h", i,
          wa1_q[rb+i], src1_q[rb+i], 16'hFE00 + 16'(i), 16'h9000 + 16'(i)); end
    end
  endtask

  task automatic test_reset_mid();
    int wb, ab;
    io_wr1(8'hA0);
    repeat (99) @(negedge clk);
    @(negedge clk); rst_l = 1'b0;
    @(negedge clk);
    tests++; if ({dma1.O_RDMA_RE_L, dma1.O_WDMA_WE_L, active1} !== 3'b110) begin
      fails++; $display("FAIL reset_mid_idle: got re/we/act=%b required 110", {dma1.O_RDMA_RE_L, dma1.O_WDMA_WE_L, active1}); end
    tests++; if (dread1 !== 8'h00 || dma1.O_RDMA_ADDR !== 16'h0000) begin
      fails++; $display("FAIL reset_mid_regs: got reg=%h src=%h required 00/0000", dread1, dma1.O_RDMA_ADDR); end
    rst_l = 1'b1;
    wb = wa1_q.size(); ab = act1;
    repeat (400) @(negedge clk);
    tests++; if (wa1_q.size() - wb !== 0 || act1 - ab !== 0) begin
      fails++; $display("FAIL reset_mid_quiet: got %0d writes %0d active cycles required 0/0", wa1_q.size() - wb, act1 - ab); end
  endtask

  task automatic test_latency();
    int wb, ab, rb;
    bit to;
    wb = wa2_q.size(); ab = act2; rb = relow2;
    io_wr2(8'h12);
    wait_idle(2, 100, to);
    tests++; if (to) begin fails++; $display("FAIL latency_timeout: active still 1 required 0"); end
    tests++; if (act2 - ab !== 17) begin fails++; $display("FAIL latency_active_cycles: got %0d required 17", act2 - ab); end
    tests++; if (relow2 - rb !== 12) begin fails++; $display("FAIL latency_re_low_cycles: got %0d required 12", relow2 - rb); end
    tests++; if (wa2_q.size() - wb !== 4) begin fails++; $display("FAIL latency_write_count: got %0d required 4", wa2_q.size() - wb); end
    for (int i = 0; i < 4 && wb + i < wa2_q.size(); i++) begin
      tests++;
      if (wa2_q[wb+i] !== 16'hFE00 + 16'(i) || wd2_q[wb+i] !== 8'(i) || src2_q[wb+i] !== 16'h1200 + 16'(i)) begin
        fails++; $display("FAIL latency_byte%0d: got dst=%h data=%h src=%h required %h/%h/%h", i,
          wa2_q[wb+i], wd2_q[wb+i], src2_q[wb+i], 16'hFE00 + 16'(i), 8'(i), 16'h1200 + 16'(i)); end
    end
  endtask

  task automatic test_abandon_read();
    int wb, ab;
    bit to;
    wb = wa2_q.size(); ab = act2;
    io_wr2(8'h20);
    repeat (2) @(negedge clk);
    tests++; if (dma2.O_RDMA_RE_L !== 1'b0 || dma2.O_RDMA_ADDR !== 16'h2000) begin
      fails++; $display("FAIL abandon_first_read: got re=%b addr=%h required 0/2000", dma2.O_RDMA_RE_L, dma2.O_RDMA_ADDR); end
    io_wr2(8'h40);
    wait_idle(2, 100, to);
    tests++; if (to) begin fails++; $display("FAIL abandon_timeout: active still 1 required 0"); end
    tests++; if (act2 - ab !== 20) begin fails++; $display("FAIL abandon_active_cycles: got %0d required 20", act2 - ab); end
    tests++; if (wa2_q.size() - wb !== 4) begin fails++; $display("FAIL abandon_write_count: got %0d required 4", wa2_q.size() - wb); end
    else begin
      tests++; if (wa2_q[wb] !== 16'hFE00 || src2_q[wb] !== 16'h4000 || wd2_q[wb] !== 8'h00) begin
        fails++; $display("FAIL abandon_first_write: got dst=%h src=%h data=%h required fe00/4000/00", wa2_q[wb], src2_q[wb], wd2_q[wb]); end
    end
  endtask

  task automatic test_final_write_restart();
    int wb, ab, mb;
    bit to;
    wb = wa2_q.size(); ab = act2;
    io_wr2(8'h12);
    repeat (16) @(negedge clk);
    io_wr2(8'h34);
    mb = wa2_q.size();
    tests++; if (mb - wb !== 4) begin fails++; $display("FAIL final_first_count: got %0d required 4", mb - wb); end
    else begin
      tests++; if (wa2_q[mb-1] !== 16'hFE03 || src2_q[mb-1] !== 16'h1203) begin
        fails++; $display("FAIL final_last_write: got dst=%h src=%h required fe03/1203", wa2_q[mb-1], src2_q[mb-1]); end
    end
    @(negedge clk);
    tests++; if ({dma2.O_RDMA_RE_L, dma2.O_WDMA_WE_L, active2} !== 3'b111) begin
      fails++; $display("FAIL final_goes_start: got re/we/act=%b required 111", {dma2.O_RDMA_RE_L, dma2.O_WDMA_WE_L, active2}); end
    @(negedge clk);
    tests++; if (dma2.O_RDMA_RE_L !== 1'b0 || dma2.O_RDMA_ADDR !== 16'h3400) begin
      fails++; $display("FAIL final_new_read: got re=%b addr=%h required 0/3400", dma2.O_RDMA_RE_L, dma2.O_RDMA_ADDR); end
    wait_idle(2, 100, to);
    tests++; if (to) begin fails++; $display("FAIL final_timeout: active still 1 required 0"); end
    tests++; if (act2 - ab !== 34) begin fails++; $display("FAIL final_active_cycles: got %0d required 34", act2 - ab); end
    tests++; if (wa2_q.size() - mb !== 4) begin fails++; $display("FAIL final_second_count: got %0d required 4", wa2_q.size() - mb); end
    for (int i = 0; i < 4 && mb + i < wa2_q.size(); i++) begin
      tests++;
      if (src2_q[mb+i] !== 16'h3400 + 16'(i) || wa2_q[mb+i] !== 16'hFE00 + 16'(i)) begin
        fails++; $display("FAIL final_byte%0d: got src=%h dst=%h required %h/%h", i,
          src2_q[mb+i], wa2_q[mb+i], 16'h3400 + 16'(i), 16'hFE00 + 16'(i)); end
    end
    tests++; if (ovl2 !== 0) begin fails++; $display("FAIL lat_strobe_overlap: got %0d required 0", ovl2); end
  endtask

  initial begin
    rst_l = 1'b0;
    addr1 = 16'h0; we1 = 1'b1; re1 = 1'b1; io1_drv = 1'b0; io1_val = 8'h00;
    addr2 = 16'h0; we2 = 1'b1; re2 = 1'b1; io2_drv = 1'b0; io2_val = 8'h00;
    test_reset();
    test_basic();
    test_readback_echo();
    test_restart();
    test_reset_mid();
    test_latency();
    test_abandon_read();
    test_final_write_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
